// File: rtl/fft_cbfp_scale.sv
// rtl/fft_cbfp_scale.sv - convergent block floating point rescaler for parallel FFT output beats
// Ping-pong buffers blocks of array_num beats, then emits them shifted by the block-wide minimum sign count.
module fft_cbfp_scale #(
    parameter int array_size = 16,
    parameter int array_num  = 4,
    parameter int din_size   = 23,
    parameter int dout_size  = 11,
    parameter int cnt_size   = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  valid_in,
    input  logic [array_size-1:0][din_size-1:0]   din_re,
    input  logic [array_size-1:0][din_size-1:0]   din_im,
    input  logic [cnt_size-1:0]                   cnt_re_in,
    input  logic [cnt_size-1:0]                   cnt_im_in,
    output logic                                  valid_out,
    output logic                                  blk_start_out,
    output logic [array_size-1:0][dout_size-1:0]  dout_re,
    output logic [array_size-1:0][dout_size-1:0]  dout_im,
    output logic [cnt_size-1:0]                   exp_out
);

    localparam int bw = (array_num > 1) ? $clog2(array_num) : 1;
    localparam logic [bw-1:0]        last_beat = bw'(array_num - 1);
    localparam logic [cnt_size-1:0]  cnt_max   = cnt_size'(din_size - 1);
    localparam logic [dout_size-1:0] max_pos   = {1'b0, {(dout_size-1){1'b1}}};

    typedef enum logic {IDLE, OUT} state_t;

    logic [array_size-1:0][din_size-1:0] mem_re [2][array_num];
    logic [array_size-1:0][din_size-1:0] mem_im [2][array_num];
    logic [cnt_size-1:0]                 bank_exp [2];
    logic [1:0]                          full;

    logic                wr_bank;
    logic [bw-1:0]       wr_cnt;
    logic [cnt_size-1:0] run_min;
    logic                wr_last;
    logic [cnt_size-1:0] re_c, im_c, beat_min, blk_min_next;

    state_t              state, next_state;
    logic                rd_bank;
    logic [bw-1:0]       rd_cnt;
    logic                emit, rd_done;

    logic [array_size-1:0][dout_size-1:0] scl_re, scl_im;

    function automatic logic [cnt_size-1:0] clamp(input logic [cnt_size-1:0] c);
        return (c > cnt_max) ? cnt_max : c;
    endfunction

    function automatic logic [cnt_size-1:0] min_cnt(input logic [cnt_size-1:0] a,
                                                    input logic [cnt_size-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Bits below the kept field supply the round bit; only the top positive code can overflow.
    function automatic logic [dout_size-1:0] scale(input logic [din_size-1:0] x,
                                                   input logic [cnt_size-1:0] sh);
        logic [din_size-1:0]  shifted;
        logic [dout_size-1:0] top;
        logic                 rnd;
        shifted = x << sh;
        top     = shifted[din_size-1 -: dout_size];
        rnd     = shifted[din_size-dout_size-1];
        if (rnd && (top == max_pos))
            return max_pos;
        return top + dout_size'(rnd);
    endfunction

    always_comb begin
        re_c         = clamp(cnt_re_in);
        im_c         = clamp(cnt_im_in);
        beat_min     = min_cnt(re_c, im_c);
        blk_min_next = (wr_cnt == '0) ? beat_min : min_cnt(run_min, beat_min);
        wr_last      = (wr_cnt == last_beat);
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            mem_re[wr_bank][wr_cnt] <= din_re;
            mem_im[wr_bank][wr_cnt] <= din_im;
            if (wr_last)
                bank_exp[wr_bank] <= blk_min_next;
        end
    end

    // Clear precedes set so a bank drained this cycle can be refilled immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            run_min <= '0;
            full    <= 2'b00;
        end else begin
            if (rd_done)
                full[rd_bank] <= 1'b0;
            if (valid_in) begin
                run_min <= blk_min_next;
                if (wr_last) begin
                    wr_cnt        <= '0;
                    wr_bank       <= ~wr_bank;
                    full[wr_bank] <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        emit       = (state == OUT) || full[rd_bank];
        rd_done    = emit && (rd_cnt == last_beat);
        if (rd_done)
            next_state = full[~rd_bank] ? OUT : IDLE;
        else if (emit)
            next_state = OUT;
    end

    always_comb begin
        for (int i = 0; i < array_size; i++) begin
            scl_re[i] = scale(mem_re[rd_bank][rd_cnt][i], bank_exp[rd_bank]);
            scl_im[i] = scale(mem_im[rd_bank][rd_cnt][i], bank_exp[rd_bank]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_bank       <= 1'b0;
            rd_cnt        <= '0;
            valid_out     <= 1'b0;
            blk_start_out <= 1'b0;
            exp_out       <= '0;
            dout_re       <= '0;
            dout_im       <= '0;
        end else begin
            state         <= next_state;
            valid_out     <= emit;
            blk_start_out <= emit && (rd_cnt == '0);
            if (emit) begin
                rd_cnt  <= rd_done ? '0 : rd_cnt + 1'b1;
                exp_out <= bank_exp[rd_bank];
                dout_re <= scl_re;
                dout_im <= scl_im;
            end
            if (rd_done)
                rd_bank <= ~rd_bank;
        end
    end

endmodule

// File: tb/tb_fft_cbfp_scale.sv
// tb/tb_fft_cbfp_scale.sv - directed bench for fft_cbfp_scale with a block-level reference model
module tb_fft_cbfp_scale;

    localparam int AS = 16;
    localparam int AN = 4;
    localparam int DW = 23;
    localparam int OW = 11;
    localparam int CW = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    valid_in;
    logic [AS-1:0][DW-1:0]   din_re, din_im;
    logic [CW-1:0]           cnt_re_in, cnt_im_in;
    logic                    valid_out, blk_start_out;
    logic [AS-1:0][OW-1:0]   dout_re, dout_im;
    logic [CW-1:0]           exp_out;

    int n_vec = 0;
    int n_err = 0;

    fft_cbfp_scale #(
        .array_size(AS), .array_num(AN), .din_size(DW), .dout_size(OW), .cnt_size(CW)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .din_re(din_re), .din_im(din_im),
        .cnt_re_in(cnt_re_in), .cnt_im_in(cnt_im_in),
        .valid_out(valid_out), .blk_start_out(blk_start_out),
        .dout_re(dout_re), .dout_im(dout_im), .exp_out(exp_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Reference: scale by 2^sh, wrap to DW bits, then floor((v + half) / 2^(DW-OW)) with saturation.
    function automatic logic [OW-1:0] m_scale(input logic [DW-1:0] s, input int sh);
        longint v, q, modv, half;
        modv = longint'(1) << DW;
        half = longint'(1) << (DW - OW - 1);
        v = longint'($signed(s)) * (longint'(1) << sh);
        v = v & (modv - 1);
        if (v >= (modv >> 1)) v = v - modv;
        q = (v + half) >>> (DW - OW);
        if (q > (longint'(1) << (OW - 1)) - 1) q = (longint'(1) << (OW - 1)) - 1;
        return OW'(q);
    endfunction

    function automatic int m_clamp(input int c);
        return (c > DW - 1) ? DW - 1 : c;
    endfunction

    typedef struct {
        int                    cyc;
        logic [AS-1:0][OW-1:0] re;
        logic [AS-1:0][OW-1:0] im;
        logic [CW-1:0]         ex;
        logic                  st;
    } ob_t;

    ob_t                   oq[$];
    ob_t                   ob, e;
    logic [AS-1:0][DW-1:0] br [AN];
    logic [AS-1:0][DW-1:0] bi [AN];
    logic [AS-1:0][OW-1:0] last_re, last_im;
    int bn, bmin, next_free, cyc, c, c2, st;

    initial begin
        cyc = 0; bn = 0; bmin = 0; next_free = 0;
        last_re = '0; last_im = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                chk("rst_valid", 256'(valid_out), 256'(0));
                chk("rst_start", 256'(blk_start_out), 256'(0));
                chk("rst_exp", 256'(exp_out), 256'(0));
                chk("rst_re", 256'(dout_re), 256'(0));
                chk("rst_im", 256'(dout_im), 256'(0));
                oq.delete();
                bn = 0; next_free = 0;
                last_re = '0; last_im = '0;
            end else begin
                if (oq.size() > 0 && oq[0].cyc == cyc) begin
                    e = oq.pop_front();
                    chk("valid", 256'(valid_out), 256'(1));
                    chk("blk_start", 256'(blk_start_out), 256'(e.st));
                    chk("exp", 256'(exp_out), 256'(e.ex));
                    chk("dout_re", 256'(dout_re), 256'(e.re));
                    chk("dout_im", 256'(dout_im), 256'(e.im));
                    last_re = e.re; last_im = e.im;
                end else begin
                    chk("idle_valid", 256'(valid_out), 256'(0));
                    chk("idle_start", 256'(blk_start_out), 256'(0));
                    chk("hold_re", 256'(dout_re), 256'(last_re));
                    chk("hold_im", 256'(dout_im), 256'(last_im));
                end
                if (valid_in) begin
                    br[bn] = din_re; bi[bn] = din_im;
                    c  = m_clamp(int'(cnt_re_in));
                    c2 = m_clamp(int'(cnt_im_in));
                    if (c2 < c) c = c2;
                    if (bn == 0 || c < bmin) bmin = c;
                    bn++;
                    if (bn == AN) begin
                        st = (cyc + 1 > next_free) ? cyc + 1 : next_free;
                        for (int b = 0; b < AN; b++) begin
                            ob.cyc = st + b;
                            ob.st  = (b == 0);
                            ob.ex  = CW'(bmin);
                            for (int i = 0; i < AS; i++) begin
                                ob.re[i] = m_scale(br[b][i], bmin);
                                ob.im[i] = m_scale(bi[b][i], bmin);
                            end
                            oq.push_back(ob);
                        end
                        next_free = st + AN;
                        bn = 0;
                    end
                end
            end
        end
    end

    task automatic beat(input int cre, input int cim);
        valid_in  = 1'b1;
        cnt_re_in = CW'(cre);
        cnt_im_in = CW'(cim);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            valid_in = 1'b0;
            for (int i = 0; i < AS; i++) begin
                din_re[i] = DW'($urandom);
                din_im[i] = DW'($urandom);
            end
            cnt_re_in = CW'($urandom);
            cnt_im_in = CW'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic fill_const(input logic [DW-1:0] re, input logic [DW-1:0] im);
        for (int i = 0; i < AS; i++) begin
            din_re[i] = re;
            din_im[i] = im;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < AS; i++) begin
            din_re[i] = DW'($urandom);
            din_im[i] = DW'($urandom);
        end
    endtask

    task automatic first_out();
        valid_in = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0;
        din_re = '0; din_im = '0; cnt_re_in = '0; cnt_im_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("model_256_sh13", 256'(m_scale(23'd256, 13)), 256'(11'd512));
        chk("model_m1_sh22", 256'(m_scale(23'h7FFFFF, 22)), 256'(11'h400));
        chk("model_sat", 256'(m_scale(23'h3FF800, 0)), 256'(11'd1023));
        chk("model_3ff000", 256'(m_scale(23'h3FF000, 0)), 256'(11'd1023));
        chk("model_800", 256'(m_scale(23'h000800, 0)), 256'(11'd1));
        chk("model_clamp", 256'(m_clamp(31)), 256'(22));

        idle(2);
        fill_const(23'd256, 23'd0);
        repeat (4) beat(13, 22);
        first_out();
        chk("a_valid", 256'(valid_out), 256'(1));
        chk("a_start", 256'(blk_start_out), 256'(1));
        chk("a_exp", 256'(exp_out), 256'(13));
        chk("a_re0", 256'(dout_re[0]), 256'(11'd512));
        chk("a_im7", 256'(dout_im[7]), 256'(11'd0));
        @(negedge clk);
        idle(6);

        fill_rand();
        beat(13, 22); beat(5, 22); beat(20, 22); beat(9, 22);
        valid_in = 1'b0;
        for (int k = 0; k < AN; k++) begin
            @(posedge clk); #1;
            chk("b_exp", 256'(exp_out), 256'(5));
        end
        @(negedge clk);
        idle(6);

        fill_const(23'h7FFFFF, 23'h7FFFFF);
        repeat (4) beat(22, 22);
        first_out();
        chk("c_re3", 256'(dout_re[3]), 256'(11'h400));
        chk("c_im15", 256'(dout_im[15]), 256'(11'h400));
        chk("c_exp", 256'(exp_out), 256'(22));
        @(negedge clk);
        idle(6);

        fill_rand();
        din_re[0] = 23'h3FF800;
        din_re[1] = 23'h3FF000;
        din_re[2] = 23'h000800;
        beat(0, 22);
        repeat (3) beat(22, 22);
        first_out();
        chk("d_sat", 256'(dout_re[0]), 256'(11'd1023));
        chk("d_3ff000", 256'(dout_re[1]), 256'(11'd1023));
        chk("d_800", 256'(dout_re[2]), 256'(11'd1));
        chk("d_exp", 256'(exp_out), 256'(0));
        @(negedge clk);
        idle(6);

        for (int k = 0; k < 2 * AN; k++) begin
            fill_rand();
            beat(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        end
        first_out();
        chk("e_blk2_valid", 256'(valid_out), 256'(1));
        chk("e_blk2_start", 256'(blk_start_out), 256'(1));
        @(negedge clk);
        idle(8);

        fill_rand(); beat(12, 14);
        fill_rand(); beat(8, 30);
        idle(3);
        fill_rand(); beat(17, 6);
        fill_rand(); beat(25, 9);
        for (int k = 0; k < AN; k++) begin
            fill_rand();
            beat(int'($urandom_range(3, 24)), int'($urandom_range(3, 24)));
        end
        idle(8);

        fill_rand(); beat(4, 7);
        fill_rand(); beat(6, 3);
        valid_in = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < AN; k++) begin
            fill_rand();
            beat(int'($urandom_range(0, 22)), int'($urandom_range(0, 22)));
        end
        valid_in = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(8);
        chk("g_quiet", 256'(valid_out), 256'(0));
        for (int k = 0; k < AN; k++) begin
            fill_rand();
            beat(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        end
        first_out();
        chk("g_fresh_valid", 256'(valid_out), 256'(1));
        @(negedge clk);
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fft_cbfp_scale.md
FFT_CBFP_SCALE -- requirements
Module: fft_cbfp_scale

Interface
REQ-001 The block SHALL have the parameter array_size, default 16, giving the parallel samples per beat per component.
REQ-002 The block SHALL have the parameter array_num, default 4, giving the beats per CBFP block.
REQ-003 The block SHALL have the parameter din_size, default 23, giving the input sample width, signed.
REQ-004 The block SHALL have the parameter dout_size, default 11, giving the output sample width, signed.
REQ-005 The block SHALL have the parameter cnt_size, default 5, giving the leading-sign-bit count width.
REQ-006 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port valid_in, input, 1 bit: the current beat is valid.
REQ-009 Port din_re, input, array_size x din_size: real samples.
REQ-010 Port din_im, input, array_size x din_size: imaginary samples.
REQ-011 Port cnt_re_in, input, cnt_size: minimum redundant-sign-bit count of din_re for this beat, beat-aligned with the data.
REQ-012 Port cnt_im_in, input, cnt_size: the same count for din_im.
REQ-013 Port valid_out, output, 1 bit: the output beat is valid.
REQ-014 Port blk_start_out, output, 1 bit: high on beat 0 of each output block.
REQ-015 Port dout_re, output, array_size x dout_size: scaled real samples.
REQ-016 Port dout_im, output, array_size x dout_size: scaled imaginary samples.
REQ-017 Port exp_out, output, cnt_size: block shift applied, constant across the block.

Function
REQ-018 Input beats SHALL be grouped in order into blocks of array_num valid beats; beats with valid_in low SHALL be ignored and SHALL NOT advance the grouping.
REQ-019 The block shift SHALL be the minimum of all 2*array_num counts (cnt_re_in and cnt_im_in) in the block; counts above din_size-1 SHALL be clamped to din_size-1.
REQ-020 Each sample SHALL be arithmetically left-shifted by the block shift to din_size bits; bits [din_size-1 : din_size-dout_size] SHALL form the result.
REQ-021 Rounding SHALL be round-half-up using bit din_size-dout_size-1 of the shifted value; a positive overflow SHALL saturate to 2^(dout_size-1)-1; negative results SHALL never round below -2^(dout_size-1).
REQ-022 Storage SHALL be a ping-pong buffer of 2 banks of array_num beats; the write bank SHALL toggle after each complete block.
REQ-023 The read side SHALL be an FSM with two states: IDLE and OUT.
REQ-024 In IDLE, when a bank is full, the FSM SHALL go to OUT on the next edge; in OUT it SHALL emit one beat per cycle, beats 0..array_num-1 in input order.
REQ-025 After the last beat, the FSM SHALL go directly to OUT on the other bank if that bank is full at that edge, otherwise to IDLE.
REQ-026 The first output beat of a block SHALL be registered on the edge after the edge that captured the block's last input beat (latency 1 cycle).
REQ-027 Continuous input SHALL give continuous output with no bubbles; no backpressure exists, and both banks SHALL never be simultaneously full.
REQ-028 A bank SHALL be writable again in the same cycle its last beat is read.
REQ-029 When valid_out is high, blk_start_out SHALL be high only on beat 0, and exp_out SHALL equal that block's shift.
REQ-030 When valid_out is low, dout_re and dout_im SHALL hold their last values and blk_start_out SHALL be 0.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 When rst is high at an edge: valid_out, blk_start_out, exp_out, dout_re and dout_im SHALL be 0; the FSM SHALL be IDLE; the write bank and beat counters SHALL be 0; both banks SHALL be empty.
REQ-033 Reset mid-block or mid-output SHALL discard all partial and pending blocks, and no stale beat SHALL appear afterward.

Verification
REQ-034 One block, all din_re = 256, all din_im = 0, counts re = 13 and im = 22 -> exp_out = 13, every dout_re = 512, every dout_im = 0, 4 valid beats starting 1 cycle after the last input.
REQ-035 re counts 13, 5, 20, 9 and im counts all 22 -> exp_out = 5 on all 4 output beats.
REQ-036 All samples = -1 with all counts 22 -> dout = -1024 and exp_out = 22.
REQ-037 Shift 0, sample 0x3FF800 -> 1023 (saturated, not 1024); sample 0x3FF000 -> 1023; sample 0x000800 -> 1.
REQ-038 Two blocks back-to-back (8 consecutive valid beats) -> valid_out high for 8 consecutive cycles, with blk_start_out on output beats 0 and 4; a variant with 3 idle cycles inside block 1 -> output timing per REQ-026.
REQ-039 rst pulsed after 2 beats of a block and again during output beat 2 -> valid_out low until a fresh complete block arrives, then a correct output block.
